// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm stage.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [3:0] HOUR_MAX_G = 4'd2;
  localparam logic [3:0] HOUR_MAX_D = 4'd3;
  localparam logic [3:0] MIN_MAX_G  = 4'd5;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  // Two-digit BCD increment that wraps to 00 once {max_g,max_d} is reached.
  function automatic logic [7:0] bcd2_inc(input logic [3:0] g, input logic [3:0] d,
                                          input logic [3:0] max_g, input logic [3:0] max_d);
    logic [3:0] ng;
    logic [3:0] nd;
    if (g == max_g && d == max_d) begin
      ng = 4'd0;
      nd = 4'd0;
    end else if (d == DIGIT_MAX) begin
      ng = g + 4'd1;
      nd = 4'd0;
    end else begin
      ng = g;
      nd = d + 4'd1;
    end
    return {ng, nd};
  endfunction

endpackage

// File: rtl/alarm_bcd_inc.sv
// Two-digit BCD register advanced by a single-cycle pulse, wrapping at MAX_G:MAX_D.
module alarm_bcd_inc
  import alarm_pkg::*;
#(
  parameter logic [3:0] MAX_G = HOUR_MAX_G,
  parameter logic [3:0] MAX_D = HOUR_MAX_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] dig_g,
  output logic [3:0] dig_d
);

  logic [3:0] dig_g_q, dig_g_d;
  logic [3:0] dig_d_q, dig_d_d;

  // Next digit pair: hold, or step by one with BCD carry and wrap.
  always_comb begin
    dig_g_d = dig_g_q;
    dig_d_d = dig_d_q;
    if (inc) begin
      {dig_g_d, dig_d_d} = bcd2_inc(dig_g_q, dig_d_q, MAX_G, MAX_D);
    end
  end

  // Digit registers, cleared to 00 on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_g_q <= 4'd0;
      dig_d_q <= 4'd0;
    end else begin
      dig_g_q <= dig_g_d;
      dig_d_q <= dig_d_d;
    end
  end

  assign dig_g = dig_g_q;
  assign dig_d = dig_d_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm time storage, match detection and ring/snooze state machine driving the buzzer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       st_alam,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  input  logic [3:0] hour_g,
  input  logic [3:0] hour_d,
  input  logic [3:0] min_g,
  input  logic [3:0] min_d,
  input  logic [3:0] sec_g,
  input  logic [3:0] sec_d,
  output logic [3:0] alm_hour_g,
  output logic [3:0] alm_hour_d,
  output logic [3:0] alm_min_g,
  output logic [3:0] alm_min_d,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzz
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
  localparam int USED_W = $clog2(MAX_SNOOZE + 1);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
  localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
  localparam logic [USED_W-1:0] USED_MAX  = USED_W'(MAX_SNOOZE);
  localparam logic [USED_W-1:0] USED_ONE  = USED_W'(1);

  alarm_state_e      state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [USED_W-1:0] snooze_used_q, snooze_used_d;
  logic              beat_q, beat_d;
  logic              match_q, match_d;
  logic              trig;

  alarm_bcd_inc #(.MAX_G(HOUR_MAX_G), .MAX_D(HOUR_MAX_D)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_hour & st_alam),
    .dig_g (alm_hour_g),
    .dig_d (alm_hour_d)
  );

  alarm_bcd_inc #(.MAX_G(MIN_MAX_G), .MAX_D(DIGIT_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_min & st_alam),
    .dig_g (alm_min_g),
    .dig_d (alm_min_d)
  );

  // Match on the first second of the alarm minute; trigger on its rising edge only.
  always_comb begin
    match_d = alarm_en & ~st_alam &
              (hour_g == alm_hour_g) & (hour_d == alm_hour_d) &
              (min_g == alm_min_g) & (min_d == alm_min_d) &
              (sec_g == 4'd0) & (sec_d == 4'd0);
    trig = match_d & ~match_q;
  end

  // Next state and counters, evaluated in priority order.
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    snooze_used_d = snooze_used_q;
    beat_d        = beat_q;
    if (st_alam) begin
      state_d       = IDLE;
      ring_cnt_d    = '0;
      snz_cnt_d     = '0;
      snooze_used_d = '0;
      beat_d        = 1'b1;
    end else if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        RING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze && snooze_used_q < USED_MAX) begin
            state_d       = SNOOZE;
            snz_cnt_d     = SNZ_LOAD;
            snooze_used_d = snooze_used_q + USED_ONE;
          end else if (tick_1hz) begin
            beat_d = ~beat_q;
            if (ring_cnt_q != '0) ring_cnt_d = ring_cnt_q - RING_ONE;
            if (ring_cnt_q <= RING_ONE) state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick_1hz) begin
            if (snz_cnt_q <= SNZ_ONE) begin
              state_d    = RING;
              snz_cnt_d  = '0;
              ring_cnt_d = RING_LOAD;
              beat_d     = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_ONE;
            end
          end
        end
        default: begin
          if (trig) begin
            state_d       = RING;
            ring_cnt_d    = RING_LOAD;
            beat_d        = 1'b1;
            snooze_used_d = '0;
          end
        end
      endcase
    end
  end

  // State, counter and match registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      snooze_used_q <= '0;
      beat_q        <= 1'b1;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snooze_used_q <= snooze_used_d;
      beat_q        <= beat_d;
      match_q       <= match_d;
    end
  end

  assign ringing  = (state_q == RING);
  assign snoozing = (state_q == SNOOZE);
  assign buzz     = ringing & beat_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl with a seconds-level behavioural reference.
module tb_alarm_ctrl;

  localparam int RS  = 4;
  localparam int SS  = 3;
  localparam int MXS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_1hz = 1'b0, st_alam = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
  logic alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
  int   t_h = 0, t_m = 0, t_s = 0;
  logic [3:0] hour_g, hour_d, min_g, min_d, sec_g, sec_d;
  logic [3:0] alm_hour_g, alm_hour_d, alm_min_g, alm_min_d;
  logic ringing, snoozing, buzz;

  assign hour_g = 4'(t_h / 10);
  assign hour_d = 4'(t_h % 10);
  assign min_g  = 4'(t_m / 10);
  assign min_d  = 4'(t_m % 10);
  assign sec_g  = 4'(t_s / 10);
  assign sec_d  = 4'(t_s % 10);

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MXS)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .st_alam(st_alam),
    .inc_hour(inc_hour), .inc_min(inc_min), .alarm_en(alarm_en),
    .snooze(snooze), .stop(stop),
    .hour_g(hour_g), .hour_d(hour_d), .min_g(min_g), .min_d(min_d),
    .sec_g(sec_g), .sec_d(sec_d),
    .alm_hour_g(alm_hour_g), .alm_hour_d(alm_hour_d),
    .alm_min_g(alm_min_g), .alm_min_d(alm_min_d),
    .ringing(ringing), .snoozing(snoozing), .buzz(buzz)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: alarm time as plain hour/minute numbers, a mode (0 idle, 1 ringing,
  // 2 snoozing), seconds left in the current phase, snoozes taken, beat, last match.
  int m_ah = 0, m_am = 0, m_mode = 0, m_left = 0, m_used = 0;
  bit m_beat = 1'b1, m_prev = 1'b0;

  task automatic model_step();
    bit m;
    if (reset) begin
      m_ah = 0; m_am = 0; m_mode = 0; m_left = 0; m_used = 0; m_beat = 1; m_prev = 0;
      return;
    end
    m = alarm_en && !st_alam && t_h == m_ah && t_m == m_am && t_s == 0;
    if (st_alam) begin
      if (inc_hour) m_ah = (m_ah + 1) % 24;
      if (inc_min)  m_am = (m_am + 1) % 60;
      m_mode = 0; m_left = 0; m_used = 0; m_beat = 1;
    end else if (!alarm_en) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (snooze && m_used < MXS) begin m_mode = 2; m_left = SS; m_used++; end
      else if (tick_1hz) begin
        m_beat = !m_beat;
        m_left--;
        if (m_left <= 0) m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (stop) m_mode = 0;
      else if (tick_1hz) begin
        m_left--;
        if (m_left <= 0) begin m_mode = 1; m_left = RS; m_beat = 1; end
      end
    end else if (m && !m_prev) begin
      m_mode = 1; m_left = RS; m_beat = 1; m_used = 0;
    end
    m_prev = m;
  endtask

  // Advance the reference on every active edge, compare on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("alm_hour_g", alm_hour_g, m_ah / 10);
      chk("alm_hour_d", alm_hour_d, m_ah % 10);
      chk("alm_min_g", alm_min_g, m_am / 10);
      chk("alm_min_d", alm_min_d, m_am % 10);
      chk("ringing", ringing, int'(m_mode == 1));
      chk("snoozing", snoozing, int'(m_mode == 2));
      chk("buzz", buzz, int'(m_mode == 1 && m_beat));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick_1hz = 1; step(1); tick_1hz = 0; step(1);
  endtask

  task automatic pulse_snooze();
    snooze = 1; step(1); snooze = 0;
  endtask

  // Bring the alarm into RING from IDLE via a fresh 07:29:59 -> 07:30:00 edge.
  task automatic ring_up(input string name);
    stop = 1; step(1); stop = 0;
    t_h = 7; t_m = 29; t_s = 59; step(1);
    t_m = 30; t_s = 0; step(1);
    chk(name, ringing, 1);
  endtask

  initial begin
    step(3);
    chk("reset_ringing", ringing, 0);
    chk("reset_buzz", buzz, 0);
    chk("reset_alm", {alm_hour_g, alm_hour_d, alm_min_g, alm_min_d}, 0);
    reset = 0;

    // Set mode: 7 hour steps and 30 minute steps, then full wraps.
    st_alam = 1;
    inc_hour = 1; step(7); inc_hour = 0;
    inc_min = 1; step(30); inc_min = 0;
    step(1);
    chk("set_0730", {alm_hour_g, alm_hour_d, alm_min_g, alm_min_d}, 16'h0730);
    inc_hour = 1; step(24); inc_hour = 0; step(1);
    chk("hour_wrap", {alm_hour_g, alm_hour_d}, 8'h07);
    inc_min = 1; step(60); inc_min = 0; step(1);
    chk("min_wrap", {alm_min_g, alm_min_d}, 8'h30);
    st_alam = 0;

    // Trigger: one cycle after the match edge, single trigger while held.
    alarm_en = 1;
    t_h = 7; t_m = 29; t_s = 59; step(2);
    chk("pre_match", ringing, 0);
    t_m = 30; t_s = 0; step(1);
    chk("trig_ring", ringing, 1);
    chk("trig_buzz", buzz, 1);
    step(10);
    chk("held_ring", ringing, 1);

    // Beat toggles per tick; timeout after the fourth tick, no retrigger.
    pulse_tick(); chk("beat1", buzz, 0);
    pulse_tick(); chk("beat2", buzz, 1);
    pulse_tick(); chk("beat3", buzz, 0);
    chk("ring3", ringing, 1);
    pulse_tick(); chk("timeout", ringing, 0);
    t_s = 1; step(3);
    chk("no_retrig", ringing, 0);

    // Snooze cycles up to the limit, the extra one is ignored.
    ring_up("snz_ring");
    for (int k = 0; k < MXS; k++) begin
      pulse_snooze();
      chk("snoozing", snoozing, 1);
      chk("snz_buzz", buzz, 0);
      pulse_tick(); pulse_tick();
      chk("snz_wait", snoozing, 1);
      pulse_tick();
      chk("snz_back", ringing, 1);
    end
    pulse_snooze();
    chk("snz_ignored", ringing, 1);

    // Priorities.
    stop = 1; snooze = 1; step(1); stop = 0; snooze = 0;
    chk("stop_over_snz", ringing | snoozing, 0);
    ring_up("en_ring");
    pulse_snooze();
    alarm_en = 0; step(1);
    chk("en_off", snoozing | ringing, 0);
    alarm_en = 1;
    ring_up("st_ring");
    st_alam = 1; step(1); st_alam = 0;
    chk("st_alam_idle", ringing, 0);
    ring_up("rst_ring");
    reset = 1; step(1);
    chk("rst_outs", {ringing, snoozing, buzz}, 0);
    chk("rst_alm", {alm_hour_g, alm_hour_d, alm_min_g, alm_min_d}, 0);
    reset = 0;

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 599) == 0);
      st_alam  = ($urandom_range(0, 39) == 0);
      inc_hour = st_alam & $urandom_range(0, 1);
      inc_min  = st_alam & $urandom_range(0, 1);
      alarm_en = ($urandom_range(0, 15) != 0);
      tick_1hz = ($urandom_range(0, 3) == 0);
      snooze   = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: begin t_h = m_ah; t_m = m_am; t_s = 0; end
          2: begin t_h = m_ah; t_m = m_am; t_s = 59; end
          default: begin
            t_h = $urandom_range(0, 23); t_m = $urandom_range(0, 59); t_s = $urandom_range(0, 59);
          end
        endcase
      end
      step(1);
    end
    reset = 0; st_alam = 0; inc_hour = 0; inc_min = 0;
    tick_1hz = 0; snooze = 0; stop = 0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm stage directly downstream of the hour/minute/second counters; consumes their BCD digits (hour_g/hour_d, min_g/min_d, sec_g/sec_d).
- Holds a user-set alarm time (HH:MM, BCD), detects the match, and runs a ring/snooze state machine that drives the buzzer.
- The alarm time is edited while st_alam is high, using the same button pulses that set the clock.

Parameters:
- RING_SECS, 60, number of tick_1hz seconds a ring lasts before self-cancel.
- SNOOZE_SECS, 300, number of tick_1hz seconds spent silent after a snooze press.
- MAX_SNOOZE, 3, number of snoozes honoured per alarm event; further snooze presses are ignored.

Ports:
- clk  in  1  system clock; the single clock for this block.
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle enable, once per second.
- st_alam  in  1  alarm-set mode.
- inc_hour  in  1  one-cycle pulse; alarm hour +1 while st_alam.
- inc_min  in  1  one-cycle pulse; alarm minute +1 while st_alam.
- alarm_en  in  1  alarm armed.
- snooze  in  1  one-cycle pulse.
- stop  in  1  one-cycle pulse.
- hour_g, hour_d, min_g, min_d, sec_g, sec_d  in  4 each  current time, BCD.
- alm_hour_g, alm_hour_d, alm_min_g, alm_min_d  out  4 each  stored alarm time, BCD.
- ringing  out  1  state==RING.
- snoozing  out  1  state==SNOOZE.
- buzz  out  1  ringing AND beat; the buzzer drive.

Behaviour:
- Reset (sync, high): all alarm digits 0; state IDLE; ring_cnt, snz_cnt and snooze_used cleared; beat=1; match_q=0. All outputs read 0 on the cycle after reset is sampled, except buzz, which is 0 because ringing=0.
- Set mode (st_alam=1):
  - inc_hour: 00→…→23→00. BCD units digit wraps 9→0 with tens +1; 23→00.
  - inc_min: 00→59→00. No carry into the hour.
  - inc_hour and inc_min in the same cycle both apply.
  - Update is visible on the next cycle.
  - State is forced to IDLE; all counters are cleared.
- Match: match = alarm_en & !st_alam & hh:mm equals the alarm digits & sec_g==0 & sec_d==0. match_q is match registered.
- Trigger: trig = match & !match_q, i.e. a rising edge only, so one trigger per alarm minute.
- States:
  - IDLE: on trig → RING; ring_cnt=RING_SECS, beat=1, snooze_used=0.
  - RING:
    - On each tick_1hz: beat toggles and ring_cnt decrements.
    - If ring_cnt==1 on a tick → IDLE (ring timeout).
    - stop → IDLE.
    - snooze with snooze_used<MAX_SNOOZE → SNOOZE; snz_cnt=SNOOZE_SECS, snooze_used+1.
    - snooze with snooze_used==MAX_SNOOZE → ignored.
  - SNOOZE:
    - On each tick_1hz: snz_cnt decrements.
    - If snz_cnt==1 on a tick → RING; ring_cnt reloaded to RING_SECS, beat=1.
    - stop → IDLE.
- Priority, highest first: reset > st_alam > !alarm_en (forces IDLE next cycle) > stop > snooze > timers/tick > trig.
- trig while in RING or SNOOZE is ignored.
- stop or snooze while in IDLE has no effect.
- snooze and tick_1hz in the same cycle in RING: snooze wins; ring_cnt does not matter afterwards.
- Counter widths: $clog2(param+1) bits. All counters are unsigned and never underflow.
- Outputs are registered or decoded from registered state. Latency from trig to ringing=1 is 1 cycle.
- Current-time inputs are synchronous to clk and stable between the upstream counter updates.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, RING, SNOOZE}.
  - BCD limit constants: HOUR_MAX_G=2, HOUR_MAX_D=3, MIN_MAX_G=5, DIGIT_MAX=9.
- One sub-module, alarm_bcd_inc:
  - 2-digit BCD register with inc pulse and parameterised max (23 or 59).
  - Synchronous reset to 00.
  - Instantiated twice, once for hours and once for minutes.

Test Plan:
- Set: reset; st_alam=1; 7 inc_hour and 30 inc_min pulses → alm = 0,7 : 3,0. 24 further inc_hour → alarm hour back to 07. 60 inc_min → alarm minute back to 30.
- Trigger: alarm 07:30, alarm_en=1, time steps 07:29:59 → 07:30:00 → ringing=1 one cycle later.
  - Time held at 07:30:00 for 10 cycles → exactly one trigger.
  - buzz toggles on each tick.
- Timeout: RING_SECS=4 (override) → ringing drops after the 4th tick; state IDLE; no retrigger at 07:30:01.
- Snooze: ring, then snooze → snoozing=1, buzz=0. After SNOOZE_SECS=3 ticks → ringing=1 again.
  - Repeat until MAX_SNOOZE=2 are used; the 3rd snooze is ignored (ringing stays 1).
- Priority: stop and snooze in the same cycle during RING → IDLE.
  - alarm_en=0 during SNOOZE → IDLE next cycle.
  - st_alam=1 during RING → ringing=0 next cycle.
- Reset mid-ring: assert reset while in RING → next cycle: all outputs 0, alarm digits 00:00.
